// File: rtl/tetris_pkg.sv
// Shared Tetris definitions: gravity state encoding and timing defaults.
package tetris_pkg;

  localparam int LEVEL_W_DEF    = 4;
  localparam int BASE_TICKS_DEF = 5;
  localparam int MIN_TICKS_DEF  = 1;
  localparam int LOCK_TICKS_DEF = 3;
  localparam int CNT_W_DEF      = 8;

  // Values double as the state_o debug/LED code.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_REQ    = 3'd2,
    ST_LOCK   = 3'd3,
    ST_PAUSED = 3'd4
  } gravity_state_t;

endpackage

// File: rtl/gravity_thr_calc.sv
// Ticks-per-drop clamp: soft drop or max(BASE_TICKS - level, MIN_TICKS).
// Shared with the HUD speed display, so it stays purely combinational.
module gravity_thr_calc
  import tetris_pkg::*;
#(
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int BASE_TICKS = BASE_TICKS_DEF,
  parameter int MIN_TICKS  = MIN_TICKS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  output logic [CNT_W-1:0]   thr
);

  localparam logic [CNT_W:0] BASE_EXT = (CNT_W+1)'(BASE_TICKS);
  localparam logic [CNT_W:0] MIN_EXT  = (CNT_W+1)'(MIN_TICKS);

  logic [CNT_W:0] level_ext;
  logic [CNT_W:0] diff;

  // One extra bit on the subtraction: its top bit is the borrow, so a high
  // level clamps to MIN_TICKS instead of wrapping to a huge interval.
  always_comb begin
    level_ext = (CNT_W+1)'(level);
    diff      = BASE_EXT - level_ext;
    if (soft_drop) begin
      thr = CNT_W'(MIN_TICKS);
    end else if (diff[CNT_W] || (diff < MIN_EXT)) begin
      thr = CNT_W'(MIN_TICKS);
    end else begin
      thr = diff[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/gravity_drop_timer.sv
// Gravity timer: turns the 0.2 s divider tick into held drop requests at a
// level-dependent interval, and times the lock delay of a landed piece.
module gravity_drop_timer
  import tetris_pkg::*;
#(
  parameter int LEVEL_W    = LEVEL_W_DEF,
  parameter int BASE_TICKS = BASE_TICKS_DEF,
  parameter int MIN_TICKS  = MIN_TICKS_DEF,
  parameter int LOCK_TICKS = LOCK_TICKS_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_in,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  input  logic               soft_drop,
  input  logic               landed,
  input  logic               drop_ack,
  output logic               drop_req,
  output logic               lock_req,
  output logic [2:0]         state_o
);

  gravity_state_t state, state_n;
  gravity_state_t saved_state, saved_state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] thr;
  logic [CNT_W:0]   cnt_inc;
  logic             lock_n;

  gravity_thr_calc #(
    .LEVEL_W   (LEVEL_W),
    .BASE_TICKS(BASE_TICKS),
    .MIN_TICKS (MIN_TICKS),
    .CNT_W     (CNT_W)
  ) u_thr_calc (
    .level    (level),
    .soft_drop(soft_drop),
    .thr      (thr)
  );

  // Next state / counter: abort beats pause, pause beats tick and handshake.
  always_comb begin
    state_n       = state;
    saved_state_n = saved_state;
    cnt_n         = cnt;
    lock_n        = 1'b0;
    cnt_inc       = {1'b0, cnt} + 1'b1;

    if (abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end
        end

        ST_RUN: begin
          if (pause) begin
            state_n       = ST_PAUSED;
            saved_state_n = ST_RUN;
          end else if (tick_in) begin
            if (landed) begin
              state_n = ST_LOCK;
              cnt_n   = '0;
            end else if (cnt_inc >= {1'b0, thr}) begin
              state_n = ST_REQ;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc[CNT_W-1:0];
            end
          end
        end

        // Ticks are dropped here; a pending pause takes effect only with the ack.
        ST_REQ: begin
          if (drop_ack) begin
            cnt_n = '0;
            if (pause) begin
              state_n       = ST_PAUSED;
              saved_state_n = landed ? ST_LOCK : ST_RUN;
            end else begin
              state_n = landed ? ST_LOCK : ST_RUN;
            end
          end
        end

        ST_LOCK: begin
          if (pause) begin
            state_n       = ST_PAUSED;
            saved_state_n = ST_LOCK;
          end else if (!landed) begin
            state_n = ST_RUN;
            cnt_n   = '0;
          end else if (tick_in) begin
            if (cnt_inc == (CNT_W+1)'(LOCK_TICKS)) begin
              lock_n  = 1'b1;
              state_n = ST_RUN;
              cnt_n   = '0;
            end else begin
              cnt_n = cnt_inc[CNT_W-1:0];
            end
          end
        end

        ST_PAUSED: begin
          if (!pause) begin
            state_n = saved_state;
          end
        end

        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      saved_state <= ST_RUN;
      cnt         <= '0;
      drop_req    <= 1'b0;
      lock_req    <= 1'b0;
    end else begin
      state       <= state_n;
      saved_state <= saved_state_n;
      cnt         <= cnt_n;
      drop_req    <= (state_n == ST_REQ);
      lock_req    <= lock_n;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_gravity_drop_timer.sv
// Directed bench for gravity_drop_timer with an expected-result queue.
module tb_gravity_drop_timer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick_in = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pause = 1'b0;
  logic [3:0] level = 4'd0;
  logic       soft_drop = 1'b0;
  logic       landed = 1'b0;
  logic       drop_ack = 1'b0;
  logic       drop_req;
  logic       lock_req;
  logic [2:0] state_o;

  typedef struct {
    logic [2:0] st;
    logic       dr;
    logic       lr;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_RUN = 3'd1, S_REQ = 3'd2,
                         S_LOCK = 3'd3, S_PAUSED = 3'd4;

  gravity_drop_timer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_in  (tick_in),
    .start    (start),
    .abort    (abort),
    .pause    (pause),
    .level    (level),
    .soft_drop(soft_drop),
    .landed   (landed),
    .drop_ack (drop_ack),
    .drop_req (drop_req),
    .lock_req (lock_req),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it against the DUT outputs.
  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL scoreboard_empty actual=0 entries required=1");
      return;
    end
    e = sb_q.pop_front();
    n_checks++;
    assert (state_o === e.st) else begin
      n_fails++;
      $error("[TB] FAIL %s state_o actual=%0d required=%0d", e.tag, state_o, e.st);
    end
    n_checks++;
    assert (drop_req === e.dr) else begin
      n_fails++;
      $error("[TB] FAIL %s drop_req actual=%0b required=%0b", e.tag, drop_req, e.dr);
    end
    n_checks++;
    assert (lock_req === e.lr) else begin
      n_fails++;
      $error("[TB] FAIL %s lock_req actual=%0b required=%0b", e.tag, lock_req, e.lr);
    end
  endtask

  // Drive tick/ack for one cycle, queue the outputs expected after that edge.
  task automatic applyStimulus(input logic t, input logic a, input logic [2:0] es,
                               input logic ed, input logic el, input string tag);
    exp_t e;
    e.st = es; e.dr = ed; e.lr = el; e.tag = tag;
    tick_in  = t;
    drop_ack = a;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    tick_in  = 1'b0;
    drop_ack = 1'b0;
    checkOutput();
  endtask

  initial begin
    #1;
    // Reset state
    applyStimulus(0, 0, S_IDLE, 0, 0, "reset");
    rst_n = 1'b1;
    applyStimulus(1, 0, S_IDLE, 0, 0, "idle_tick_ignored");

    // Level 0: drop the cycle after the fifth tick, held until ack
    start = 1'b1;
    applyStimulus(0, 0, S_RUN, 0, 0, "start");
    start = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, S_RUN, 0, 0, "lvl0_count");
    applyStimulus(1, 0, S_REQ, 1, 0, "lvl0_fire");
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, S_REQ, 1, 0, "lvl0_hold");
    applyStimulus(0, 1, S_RUN, 0, 0, "lvl0_ack");

    // Level 3: every 2 ticks
    level = 4'd3;
    applyStimulus(1, 0, S_RUN, 0, 0, "lvl3_count");
    applyStimulus(1, 0, S_REQ, 1, 0, "lvl3_fire");
    applyStimulus(0, 1, S_RUN, 0, 0, "lvl3_ack");

    // Level 15: clamped to every tick
    level = 4'd15;
    applyStimulus(1, 0, S_REQ, 1, 0, "lvl15_fire");
    applyStimulus(0, 1, S_RUN, 0, 0, "lvl15_ack");

    // Soft drop at level 0: every tick
    level = 4'd0;
    soft_drop = 1'b1;
    applyStimulus(1, 0, S_REQ, 1, 0, "soft_fire");
    applyStimulus(0, 1, S_RUN, 0, 0, "soft_ack");
    soft_drop = 1'b0;

    // Lock path: ack while landed, lock pulse on third tick
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, S_RUN, 0, 0, "lock_count");
    applyStimulus(1, 0, S_REQ, 1, 0, "lock_fire");
    landed = 1'b1;
    applyStimulus(0, 1, S_LOCK, 0, 0, "lock_enter");
    applyStimulus(1, 0, S_LOCK, 0, 0, "lock_t1");
    applyStimulus(1, 0, S_LOCK, 0, 0, "lock_t2");
    applyStimulus(1, 0, S_RUN, 0, 1, "lock_pulse");
    landed = 1'b0;
    applyStimulus(0, 0, S_RUN, 0, 0, "lock_pulse_end");

    // Slide off: landed drops after tick 2, no lock pulse
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, S_RUN, 0, 0, "slide_count");
    applyStimulus(1, 0, S_REQ, 1, 0, "slide_fire");
    landed = 1'b1;
    applyStimulus(0, 1, S_LOCK, 0, 0, "slide_enter");
    applyStimulus(1, 0, S_LOCK, 0, 0, "slide_t1");
    applyStimulus(1, 0, S_LOCK, 0, 0, "slide_t2");
    landed = 1'b0;
    applyStimulus(0, 0, S_RUN, 0, 0, "slide_off");
    applyStimulus(0, 0, S_RUN, 0, 0, "slide_no_lock");

    // Pause after tick 3 of 5; paused ticks are ignored, count is kept
    for (int i = 0; i < 3; i++) applyStimulus(1, 0, S_RUN, 0, 0, "pause_pre");
    pause = 1'b1;
    applyStimulus(0, 0, S_PAUSED, 0, 0, "pause_enter");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, S_PAUSED, 0, 0, "pause_ticks");
    pause = 1'b0;
    applyStimulus(0, 0, S_RUN, 0, 0, "pause_exit");
    applyStimulus(1, 0, S_RUN, 0, 0, "pause_tick4");
    applyStimulus(1, 0, S_REQ, 1, 0, "pause_tick5_fire");
    applyStimulus(0, 1, S_RUN, 0, 0, "pause_ack");

    // Pause in REQ: request held until ack, then paused
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, S_RUN, 0, 0, "preq_count");
    applyStimulus(1, 0, S_REQ, 1, 0, "preq_fire");
    pause = 1'b1;
    applyStimulus(0, 0, S_REQ, 1, 0, "preq_hold1");
    applyStimulus(1, 0, S_REQ, 1, 0, "preq_hold2");
    applyStimulus(0, 1, S_PAUSED, 0, 0, "preq_ack");
    applyStimulus(0, 0, S_PAUSED, 0, 0, "preq_stay");
    pause = 1'b0;
    applyStimulus(0, 0, S_RUN, 0, 0, "preq_resume");

    // Tick together with pause at cnt=4: tick lost, next tick fires
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, S_RUN, 0, 0, "tp_count");
    pause = 1'b1;
    applyStimulus(1, 0, S_PAUSED, 0, 0, "tp_tick_lost");
    pause = 1'b0;
    applyStimulus(0, 0, S_RUN, 0, 0, "tp_resume");
    applyStimulus(1, 0, S_REQ, 1, 0, "tp_fire");

    // Tick together with ack: tick discarded, five more ticks needed
    applyStimulus(1, 1, S_RUN, 0, 0, "ta_ack");
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, S_RUN, 0, 0, "ta_count");
    applyStimulus(1, 0, S_REQ, 1, 0, "ta_fire");

    // Reset while requesting
    rst_n = 1'b0;
    applyStimulus(0, 0, S_IDLE, 0, 0, "rst_in_req");
    rst_n = 1'b1;
    applyStimulus(0, 1, S_IDLE, 0, 0, "ack_in_idle");

    // Abort in LOCK on the tick that would have locked
    start = 1'b1;
    applyStimulus(0, 0, S_RUN, 0, 0, "ab_start");
    start = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, S_RUN, 0, 0, "ab_count");
    applyStimulus(1, 0, S_REQ, 1, 0, "ab_fire");
    landed = 1'b1;
    applyStimulus(0, 1, S_LOCK, 0, 0, "ab_lock");
    applyStimulus(1, 0, S_LOCK, 0, 0, "ab_t1");
    applyStimulus(1, 0, S_LOCK, 0, 0, "ab_t2");
    abort = 1'b1;
    applyStimulus(1, 0, S_IDLE, 0, 0, "ab_abort");
    abort = 1'b0;
    applyStimulus(1, 0, S_IDLE, 0, 0, "ab_after1");
    landed = 1'b0;
    applyStimulus(0, 0, S_IDLE, 0, 0, "ab_after2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
